multi_clock_divider: RTL and testbench

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/multi_clock_divider.sv | 65 ++++++
 tb/tb_multi_clock_divider.sv | 134 +++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH programmable 50%-duty clock dividers with glitch-free divisor updates.
// Optional macro CLKDIV_RESYNC_EN adds a resync input that phase-aligns every channel.
module multi_clock_divider #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int DEF_DIV = 2500000
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
`ifdef CLKDIV_RESYNC_EN
    input  logic              resync,
`endif
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
    output logic              wr_ack,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEF_DIV);
    logic rs;
`ifdef CLKDIV_RESYNC_EN
    assign rs = resync;
`else
    assign rs = 1'b0;
`endif
    // acknowledge only writes that target an existing channel
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) wr_ack <= 1'b0;
        else        wr_ack <= wr_en && ({1'b0, wr_ch} < 5'(NUM_CH));
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] act, shd, cnt, act_nx, cnt_nx;
        logic pend, co, tk, hit, term, zero_ld, load, co_nx;
        // terminal count, divisor hand-over (only at boundaries or from a stopped channel) and toggle
        always_comb begin
            hit     = wr_en && wr_ch == 4'(i);
            term    = en && !rs && act != '0 && cnt == act - WIDTH'(1);
            zero_ld = hit && (en || rs) && act == '0;
            load    = pend && (rs || term || (en && act == '0));
            act_nx  = zero_ld ? wr_div : load ? shd : act;
            cnt_nx  = (rs || term || act == '0) ? '0 : en ? cnt + WIDTH'(1) : cnt;
            co_nx   = (rs || act_nx == '0) ? 1'b0 : term ? ~co : co;
        end
        // channel state; tick marks the registered rising edge of clk_out
        always_ff @(posedge clk_in or negedge rst_n)
            if (!rst_n) begin
                act  <= RST_DIV;
                shd  <= RST_DIV;
                cnt  <= '0;
                pend <= 1'b0;
                co   <= 1'b0;
                tk   <= 1'b0;
            end else begin
                act  <= act_nx;
                shd  <= hit ? wr_div : shd;
                cnt  <= cnt_nx;
                pend <= hit ? !zero_ld : pend && !load;
                co   <= co_nx;
                tk   <= co_nx && !co;
            end
        assign clk_out[i] = co;
        assign tick[i]    = tk;
    end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed checks of divider timing, divisor updates, enable freeze and reset.
module tb_multi_clock_divider;
    logic       clk_in = 1'b0;
    logic       rst_n, en, wr_en, wr_ack, resync;
    logic [3:0] wr_ch, clk_out, tick;
    logic [7:0] wr_div;
    int         checks = 0, failures = 0, cyc = 0;

    multi_clock_divider #(.NUM_CH(4), .WIDTH(8), .DEF_DIV(3)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLKDIV_RESYNC_EN
        .resync(resync),
`endif
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_ack(wr_ack), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic to(input int n);
        while (cyc < n) begin
            @(posedge clk_in);
            cyc++;
        end
        #1;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [7:0] d);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; resync = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        rst_n = 1'b1; en = 1'b1; cyc = 0;
        to(2);  chk("def_pre_rise", 32'(clk_out), 0);
        to(3);  chk("def_rise", 32'(clk_out), 4'hf); chk("def_tick", 32'(tick), 4'hf);
        to(4);  chk("def_tick_once", 32'(tick), 0); chk("def_high", 32'(clk_out), 4'hf);
        to(6);  chk("def_fall", 32'(clk_out), 0);
        to(9);  chk("def_period", 32'(clk_out), 4'hf); chk("def_tick2", 32'(tick), 4'hf);
        wr(0, 5);
        to(10); wr_en = 1'b0; chk("ack_d5", 32'(wr_ack), 1);
        to(11); chk("ack_one_cycle", 32'(wr_ack), 0);
        to(12); chk("c0_old_half", 32'(clk_out[0]), 0);
        to(16); chk("c0_d5_low", 32'(clk_out[0]), 0);
        to(17); chk("c0_d5_rise", 32'(clk_out[0]), 1); chk("c0_d5_tick", 32'(tick[0]), 1);
        to(18); wr(0, 2);
        to(19); wr_en = 1'b0; chk("ack_d2", 32'(wr_ack), 1);
        to(21); chk("c0_half_complete", 32'(clk_out[0]), 1);
        to(22); chk("c0_d5_fall", 32'(clk_out[0]), 0);
        to(24); chk("c0_d2_rise", 32'(clk_out[0]), 1); chk("c0_d2_tick", 32'(tick[0]), 1);
        to(26); chk("c0_d2_fall", 32'(clk_out[0]), 0);
        to(29); wr(0, 4);
        to(30); wr_en = 1'b0; chk("ack_at_term", 32'(wr_ack), 1);
        to(31); chk("c0_term_fall", 32'(clk_out[0]), 0);
        to(32); chk("c0_old_div_kept", 32'(clk_out[0]), 1);
        to(35); chk("c0_d4_high", 32'(clk_out[0]), 1);
        to(36); chk("c0_d4_fall", 32'(clk_out[0]), 0);
        wr(9, 1);
        to(37); wr_en = 1'b0; chk("ack_bad_ch", 32'(wr_ack), 0);
        to(39); chk("c0_unchanged_low", 32'(clk_out[0]), 0);
        to(40); chk("c0_unchanged_rise", 32'(clk_out[0]), 1);
        to(41); chk("c1_unchanged_high", 32'(clk_out[1]), 1);
        to(42); chk("c1_unchanged_fall", 32'(clk_out[1]), 0);
        wr(1, 0);
        to(43); wr_en = 1'b0; chk("ack_d0", 32'(wr_ack), 1);
        to(45); chk("c1_d0_low", 32'(clk_out[1]), 0); chk("c1_d0_tick", 32'(tick[1]), 0);
        to(48); chk("c1_d0_held", 32'(clk_out[1]), 0);
        to(51); wr(1, 4);
        to(52); wr_en = 1'b0; chk("ack_wake", 32'(wr_ack), 1); chk("c1_wake_low", 32'(clk_out[1]), 0);
        to(55); chk("c1_wake_pre", 32'(clk_out[1]), 0);
        to(56); chk("c1_wake_rise", 32'(clk_out[1]), 1); chk("c1_wake_tick", 32'(tick[1]), 1);
        to(60); chk("c1_d4_fall", 32'(clk_out[1]), 0);
        to(64); chk("c1_d4_rise", 32'(clk_out[1]), 1);
        to(66); en = 1'b0;
        to(67); chk("frz_out", 32'(clk_out), 4'b0011); chk("frz_tick", 32'(tick), 0);
        to(70); wr(2, 5);
        to(71); wr_en = 1'b0; chk("frz_ack", 32'(wr_ack), 1);
        to(76); chk("frz_out_end", 32'(clk_out), 4'b0011); chk("frz_tick_end", 32'(tick), 0);
        en = 1'b1;
        to(77); chk("resume_hold", 32'(clk_out), 4'b0011);
        to(78); chk("resume_fall", 32'(clk_out), 0);
        to(79); chk("resume_rise", 32'(clk_out), 4'b1100); chk("resume_tick", 32'(tick), 4'b1100);
        to(83); chk("c2_d5_high", 32'(clk_out[2]), 1);
        to(84); chk("c2_d5_fall", 32'(clk_out[2]), 0);
        wr(3, 7);
        to(85); wr_en = 1'b0; chk("ack_pre_rst", 32'(wr_ack), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_clk_out", 32'(clk_out), 0);
        chk("arst_tick", 32'(tick), 0);
        chk("arst_wr_ack", 32'(wr_ack), 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1; cyc = 0;
        to(2);  chk("rr_pre_rise", 32'(clk_out), 0);
        to(3);  chk("rr_rise_def", 32'(clk_out), 4'hf);
        to(6);  chk("rr_fall_def", 32'(clk_out), 0);
        to(9);  chk("rr_period_def", 32'(clk_out), 4'hf);
        wr(2, 1);
        to(10); wr_en = 1'b0; chk("ack_d1", 32'(wr_ack), 1);
        to(12); chk("c2_d1_load", 32'(clk_out[2]), 0);
        to(13); chk("c2_d1_rise", 32'(clk_out[2]), 1); chk("c2_d1_tick", 32'(tick[2]), 1);
        to(14); chk("c2_d1_fall", 32'(clk_out[2]), 0);
        to(15); chk("c2_d1_rise2", 32'(clk_out[2]), 1);
        wr(3, 8'hff);
        to(16); wr_en = 1'b0; chk("ack_dmax", 32'(wr_ack), 1);
        to(18);  chk("c3_dmax_load", 32'(clk_out[3]), 0);
        to(272); chk("c3_dmax_pre", 32'(clk_out[3]), 0);
        to(273); chk("c3_dmax_rise", 32'(clk_out[3]), 1); chk("c3_dmax_tick", 32'(tick[3]), 1);
`ifdef CLKDIV_RESYNC_EN
        resync = 1'b1;
        to(274); resync = 1'b0; chk("rsy_zero", 32'(clk_out), 0);
        to(275); chk("rsy_d1", 32'(clk_out), 4'b0100);
        to(277); chk("rsy_aligned", 32'(clk_out), 4'b0111);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
